// File: rtl/seg7_scan_display_pkg.sv
// Shared widths, segment constants and the registered display payload
// for the 4-digit multiplexed 7-segment driver.
package seg7_scan_display_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DIG_N  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
    localparam logic [DIG_N-1:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry k is hex digit k
    localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [DIG_N-1:0] an;
        logic [SEG_W-1:0] seg;
        logic             dp;
    } disp_t;

    localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF, dp: 1'b1};

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG_HEX[nib];

endmodule

// File: rtl/seg7_scan_display.sv
// Captures a 16-bit debug word and scans it as 4 hex digits onto a
// common-anode display with anti-ghost blanking and leading-zero blanking.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              data_vld,
    input  logic              lzb,
    input  logic [DIG_N-1:0]  dp_mask,
    output logic [DIG_N-1:0]  an,
    output logic [SEG_W-1:0]  seg,
    output logic              dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] word;
    disp_t             disp;

    logic [NIB_W-1:0]  nib_c;
    logic [SEG_W-1:0]  hex_c;
    logic [DIG_N-1:0]  sup_c;
    logic              blank_c;
    disp_t             disp_c;

    // Prescaler, digit index, capture register and output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            idx  <= '0;
            word <= '0;
            disp <= DISP_OFF;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (data_vld) begin
                word <= data;
            end
            disp <= disp_c;
        end
    end

    assign nib_c = word[{idx, 2'b00} +: NIB_W];

    hex_to_seg7 u_hex (
        .nib   (nib_c),
        .seg_c (hex_c)
    );

    // Digit k is a leading zero when every nibble from 3 down to k is zero
    assign sup_c[3] = ~|word[15:12];
    assign sup_c[2] = ~|word[15:8];
    assign sup_c[1] = ~|word[15:4];
    assign sup_c[0] = 1'b0;

    assign blank_c = (cnt < CNT_BLANK);

    always_comb begin
        disp_c = DISP_OFF;
        if (!blank_c) begin
            disp_c.an  = ~(4'b0001 << idx);
            disp_c.seg = (lzb && sup_c[idx]) ? SEG_OFF : hex_c;
            disp_c.dp  = ~dp_mask[idx];
        end
    end

    assign an  = disp.an;
    assign seg = disp.seg;
    assign dp  = disp.dp;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized bench for seg7_scan_display against a slot/time based reference model.
module tb_seg7_scan_display;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        data_vld;
    logic        lzb;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: cycles since reset release and the held word
    int unsigned m_cyc  = 0;
    logic [15:0] m_word = 16'h0000;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_display #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .data_vld (data_vld),
        .lzb      (lzb),
        .dp_mask  (dp_mask),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b (t=%0t)",
                     tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0], $time);
        end
    endtask

    // Expected {an,seg,dp} for a given time since reset and held word
    function automatic logic [11:0] model_out(input int unsigned cyc, input logic [15:0] w,
                                              input logic l, input logic [3:0] m);
        int unsigned pos;
        int unsigned dig;
        int          top;
        logic [3:0]  nib;
        logic [3:0]  a;
        logic [6:0]  s;
        pos = cyc % DIV;
        dig = (cyc / DIV) % 4;
        if (pos < BLANK) return {4'hF, 7'h7F, 1'b1};
        top = -1;
        for (int k = 0; k < 4; k++) if (((w >> (4 * k)) & 16'hF) != 0) top = k;
        nib = 4'((w >> (4 * dig)) & 16'hF);
        a = 4'hF;
        a[dig] = 1'b0;
        if (l && dig != 0 && int'(dig) > top) s = 7'h7F;
        else s = hex_tab[nib];
        return {a, s, ~m[dig]};
    endfunction

    // Drive one cycle of inputs, advance the model and compare after the edge
    task automatic step(input string tag, input logic r, input logic [15:0] d, input logic v,
                        input logic l, input logic [3:0] m);
        logic [11:0] exp;
        rst = r; data = d; data_vld = v; lzb = l; dp_mask = m;
        @(posedge clk);
        if (!r) begin
            exp    = {4'hF, 7'h7F, 1'b1};
            m_cyc  = 0;
            m_word = 16'h0000;
        end else begin
            exp = model_out(m_cyc, m_word, l, m);
            m_cyc++;
            if (v) m_word = d;
        end
        #1;
        check_eq(tag, {an, seg, dp}, exp);
    endtask

    initial begin
        logic [15:0] rd;
        logic        rl;
        logic [3:0]  rm;
        rst = 1'b0; data = '0; data_vld = 1'b0; lzb = 1'b0; dp_mask = 4'h0;
        #2;
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 16'hFFFF, 1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 20; i++) step("zeros", 1'b1, 16'h0000, 1'b0, 1'b0, 4'h0);
        step("cap_a5c3", 1'b1, 16'hA5C3, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 20; i++) step("hold_a5c3", 1'b1, 16'h1111, 1'b0, 1'b0, 4'h0);
        step("cap_0070", 1'b1, 16'h0070, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 20; i++) step("lzb_0070", 1'b1, 16'h0000, 1'b0, 1'b1, 4'h0);
        step("cap_0000", 1'b1, 16'h0000, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 20; i++) step("lzb_0000", 1'b1, 16'h0000, 1'b0, 1'b1, 4'b0100);
        for (int i = 0; i < 10; i++) step("mid_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 4'h0);
        step("mid_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 6; i++) step("post_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 4'h0);
        step("cap_1234", 1'b1, 16'h1234, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 12; i++) step("show_1234", 1'b1, 16'h0000, 1'b0, 1'b0, 4'h0);

        rl = 1'b0; rm = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            rd = 16'($urandom);
            // Bias toward words with leading zeros so blanking gets exercised
            if ($urandom_range(0, 1) == 1) rd = rd >> (4 * $urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) rl = ~rl;
            if ($urandom_range(0, 7) == 0) rm = 4'($urandom);
            step("random", ($urandom_range(0, 99) != 0), rd, ($urandom_range(0, 7) == 0), rl, rm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
